// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - widths, opcodes and sign-magnitude conversion helpers for add_sub
package add_sub_pkg;

    localparam int IN_W      = 3;
    localparam int OUT_W     = 5;
    localparam int IN_SIGN   = IN_W - 1;
    localparam int OUT_SIGN  = OUT_W - 1;
    localparam int IN_MAG_W  = IN_W - 1;
    localparam int OUT_MAG_W = OUT_W - 1;

    typedef logic [IN_W-1:0]  sm_in_t;
    typedef logic [OUT_W-1:0] word_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Widened to OUT_W so the sum/difference of two operands cannot overflow.
    function automatic word_t sm_to_tc(input sm_in_t sm);
        word_t mag;
        mag = word_t'(sm[IN_MAG_W-1:0]);
        return sm[IN_SIGN] ? -mag : mag;
    endfunction

    // Sign is only set for a non-zero magnitude, so -0 is never produced.
    function automatic word_t tc_to_sm(input word_t tc);
        logic [OUT_MAG_W-1:0] mag;
        mag = tc[OUT_SIGN] ? -tc[OUT_MAG_W-1:0] : tc[OUT_MAG_W-1:0];
        return {tc[OUT_SIGN] && (mag != '0), mag};
    endfunction

endpackage

// File: rtl/add_sub_sm_codec.sv
// rtl/add_sub_sm_codec.sv - combinational decode of both operands and encode of the result
module add_sub_sm_codec
    import add_sub_pkg::*;
(
    input  logic [IN_W-1:0]  i_a_sm,
    input  logic [IN_W-1:0]  i_b_sm,
    input  logic [OUT_W-1:0] i_res_tc,
    output logic [OUT_W-1:0] o_a_tc,
    output logic [OUT_W-1:0] o_b_tc,
    output logic [OUT_W-1:0] o_res_sm
);

    always_comb begin
        o_a_tc   = sm_to_tc(i_a_sm);
        o_b_tc   = sm_to_tc(i_b_sm);
        o_res_sm = tc_to_sm(i_res_tc);
    end

endmodule

// File: rtl/add_sub.sv
// rtl/add_sub.sv - registered sign-magnitude adder/subtractor with zero flag, 1-cycle latency
module add_sub
    import add_sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  num1,
    input  logic [IN_W-1:0]  num2,
    input  logic             selection,
    output logic [OUT_W-1:0] result,
    output logic             zeroflag
);

    logic [OUT_W-1:0] w_a_tc;
    logic [OUT_W-1:0] w_b_tc;
    logic [OUT_W-1:0] w_res_tc;
    logic [OUT_W-1:0] w_res_sm;
    logic [OUT_W-1:0] r_result;
    logic             r_zeroflag;

    add_sub_sm_codec u_codec (
        .i_a_sm   (num1),
        .i_b_sm   (num2),
        .i_res_tc (w_res_tc),
        .o_a_tc   (w_a_tc),
        .o_b_tc   (w_b_tc),
        .o_res_sm (w_res_sm)
    );

    assign w_res_tc = (op_e'(selection) == OP_SUB) ? (w_a_tc - w_b_tc) : (w_a_tc + w_b_tc);

    // Zero flag is derived from the same encoded value so the pair is always consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_zeroflag <= 1'b1;
        end else begin
            r_result   <= w_res_sm;
            r_zeroflag <= (w_res_sm[OUT_MAG_W-1:0] == '0);
        end
    end

    assign result   = r_result;
    assign zeroflag = r_zeroflag;

endmodule

// File: tb/tb_add_sub.sv
// tb/tb_add_sub.sv - self-checking bench for add_sub: directed plan, exhaustive sweep, random ops
module tb_add_sub;

    logic       clk;
    logic       rst_n;
    logic [2:0] num1;
    logic [2:0] num2;
    logic       selection;
    logic [4:0] result;
    logic       zeroflag;

    int n_cmp;
    int n_err;

    add_sub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .num1      (num1),
        .num2      (num2),
        .selection (selection),
        .result    (result),
        .zeroflag  (zeroflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model(input logic [2:0] a, input logic [2:0] b, input logic sel);
        int va;
        int vb;
        int r;
        int ma;
        int mb;
        ma = int'(a[1:0]);
        mb = int'(b[1:0]);
        va = a[2] ? -ma : ma;
        vb = b[2] ? -mb : mb;
        r  = sel ? (va - vb) : (va + vb);
        if (r < 0) begin
            r = -r;
            return {1'b1, r[3:0]};
        end
        return {1'b0, r[3:0]};
    endfunction

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one operation, let one edge pass, then sample just after it.
    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic sel);
        num1      = a;
        num2      = b;
        selection = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [2:0] a, input logic [2:0] b,
                            input logic sel, input logic [4:0] exp_res, input logic exp_zf);
        step(a, b, sel);
        chk5({tag, "_result"}, result, exp_res);
        chk1({tag, "_zeroflag"}, zeroflag, exp_zf);
    endtask

    task automatic modelled(input string tag, input logic [2:0] a, input logic [2:0] b, input logic sel);
        logic [4:0] exp;
        exp = model(a, b, sel);
        step(a, b, sel);
        chk5(tag, result, exp);
        chk1({tag, "_zf"}, zeroflag, exp[3:0] == 4'd0);
        chk1({tag, "_zfcons"}, zeroflag, result[3:0] == 4'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        num1      = 3'b011;
        num2      = 3'b011;
        selection = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk5("reset_result", result, 5'b00000);
        chk1("reset_zeroflag", zeroflag, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk5("post_release_hold", result, 5'b00000);
        chk1("post_release_hold_zf", zeroflag, 1'b1);

        directed("add_3p3",     3'b011, 3'b011, 1'b0, 5'b00110, 1'b0);
        directed("sub_m3m3",    3'b111, 3'b011, 1'b1, 5'b10110, 1'b0);
        directed("add_negzero", 3'b100, 3'b000, 1'b0, 5'b00000, 1'b1);
        directed("sub_2m2",     3'b010, 3'b010, 1'b1, 5'b00000, 1'b1);
        directed("add_m1p2",    3'b101, 3'b010, 1'b0, 5'b00001, 1'b0);
        directed("add_m2p1",    3'b110, 3'b001, 1'b0, 5'b10001, 1'b0);
        directed("sub_1mm2",    3'b001, 3'b110, 1'b1, 5'b00011, 1'b0);

        // Reset asserted mid-cycle must clear outputs without a clock edge.
        directed("pre_reset", 3'b011, 3'b011, 1'b0, 5'b00110, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk5("async_reset_result", result, 5'b00000);
        chk1("async_reset_zf", zeroflag, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk5("after_reset_result", result, 5'b00110);
        chk1("after_reset_zf", zeroflag, 1'b0);

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    modelled($sformatf("sweep_s%0d_a%0d_b%0d", s, a, b), 3'(a), 3'(b), 1'(s));
                end
            end
        end

        for (int i = 0; i < 64; i++) begin
            logic [2:0] ra;
            logic [2:0] rb;
            logic       rs;
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            rs = 1'($urandom_range(0, 1));
            modelled($sformatf("rand%0d", i), ra, rb, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
